// File: rtl/channel_reduce_sum_pkg.sv
// Shared types and defaults for the channel_reduce_sum block.
package channel_reduce_sum_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_COUNT = 4;

    // One state per micro-step of the read/accumulate/write sequence
    typedef enum logic [3:0] {
        ST_CLEAR    = 4'd0,
        ST_INIT     = 4'd1,
        ST_WAIT_IN  = 4'd2,
        ST_POP      = 4'd3,
        ST_ACC      = 4'd4,
        ST_BRANCH   = 4'd5,
        ST_WAIT_OUT = 4'd6,
        ST_WRITE    = 4'd7,
        ST_DONE     = 4'd8
    } state_t;

endpackage

// File: rtl/channel_reduce_sum_datapath.sv
// Accumulator, element counter and last-element flag for channel_reduce_sum.
module reduce_datapath
    import channel_reduce_sum_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int COUNT = DEFAULT_COUNT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_acc,
    input  logic             acc_en,
    input  logic [WIDTH-1:0] data,
    input  logic             clr_cnt,
    input  logic             cnt_en,
    output logic [WIDTH-1:0] acc,
    output logic             last
);

    // Counter must be able to hold COUNT itself for the terminal compare
    localparam int CW = (COUNT < 2) ? 1 : $clog2(COUNT + 1);

    logic [CW-1:0]    cnt_reg;
    logic [CW-1:0]    cnt_inc;
    logic [WIDTH-1:0] acc_sum;
    logic             cnt_hit;

    // Add primitive: accumulator plus head word, wraps with no carry out
    assign acc_sum = acc + data;

    // Add primitive: element counter increment
    assign cnt_inc = cnt_reg + CW'(1);

    // Eq primitive: this pop is the final element of the run
    assign cnt_hit = (cnt_inc == CW'(COUNT));

    // Accumulator register, cleared at the start of every run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr_acc) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= acc_sum;
        end
    end

    // Element counter and last flag, updated when a word is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            last    <= 1'b0;
        end else if (clr_cnt) begin
            cnt_reg <= '0;
        end else if (cnt_en) begin
            cnt_reg <= cnt_inc;
            last    <= cnt_hit;
        end
    end

endmodule

// File: rtl/channel_reduce_sum.sv
// Reads COUNT words from an input channel, sums them and writes the result once.
module channel_reduce_sum
    import channel_reduce_sum_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int COUNT = DEFAULT_COUNT
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             valid,
    output logic [WIDTH-1:0] out_in_data,
    output logic             out_read_valid,
    output logic             out_rst,
    output logic             out_write_valid,
    input  logic [WIDTH-1:0] out_out_data,
    input  logic             out_read_ready,
    input  logic             out_write_ready,
    output logic [WIDTH-1:0] in_in_data,
    output logic             in_read_valid,
    output logic             in_rst,
    output logic             in_write_valid,
    input  logic [WIDTH-1:0] in_out_data,
    input  logic             in_read_ready,
    input  logic             in_write_ready
);

    state_t     state_reg;
    logic       last;
    logic [WIDTH-1:0] acc;
    logic       unused_inputs;

    // Channel controls this block never exercises
    assign out_read_valid = 1'b0;
    assign out_rst        = 1'b0;
    assign in_in_data     = '0;
    assign in_rst         = 1'b0;
    assign in_write_valid = 1'b0;
    assign unused_inputs  = ^{out_out_data, out_read_ready, in_write_ready};

    // Result is offered continuously; only qualified by the write strobe
    assign out_in_data = acc;

    reduce_datapath #(
        .WIDTH (WIDTH),
        .COUNT (COUNT)
    ) u_datapath (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_acc (state_reg == ST_CLEAR),
        .acc_en  (state_reg == ST_ACC),
        .data    (in_out_data),
        .clr_cnt (state_reg == ST_INIT),
        .cnt_en  ((state_reg == ST_WAIT_IN) && in_read_ready),
        .acc     (acc),
        .last    (last)
    );

    // Sequencer with registered strobes; readies only matter in the wait states
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_CLEAR;
            in_read_valid   <= 1'b0;
            out_write_valid <= 1'b0;
            valid           <= 1'b0;
        end else begin
            in_read_valid   <= 1'b0;
            out_write_valid <= 1'b0;
            case (state_reg)
                ST_CLEAR:  state_reg <= ST_INIT;
                ST_INIT:   state_reg <= ST_WAIT_IN;
                ST_WAIT_IN: begin
                    if (in_read_ready) begin
                        state_reg     <= ST_POP;
                        in_read_valid <= 1'b1;
                    end
                end
                ST_POP:    state_reg <= ST_ACC;
                ST_ACC:    state_reg <= ST_BRANCH;
                ST_BRANCH: state_reg <= last ? ST_WAIT_OUT : ST_WAIT_IN;
                ST_WAIT_OUT: begin
                    if (out_write_ready) begin
                        state_reg       <= ST_WRITE;
                        out_write_valid <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    state_reg <= ST_DONE;
                    valid     <= 1'b1;
                end
                ST_DONE:   state_reg <= ST_DONE;
                default:   state_reg <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_channel_reduce_sum.sv
// Directed bench for channel_reduce_sum with a registered-read FIFO model on the input side.
module tb_channel_reduce_sum;

    localparam int WIDTH = 32;
    localparam int COUNT = 4;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             valid;
    logic [WIDTH-1:0] out_in_data;
    logic             out_read_valid;
    logic             out_rst;
    logic             out_write_valid;
    logic [WIDTH-1:0] out_out_data = '0;
    logic             out_read_ready = 1'b0;
    logic             out_write_ready = 1'b1;
    logic [WIDTH-1:0] in_in_data;
    logic             in_read_valid;
    logic             in_rst;
    logic             in_write_valid;
    logic [WIDTH-1:0] in_out_data = '0;
    logic             in_read_ready;
    logic             in_write_ready = 1'b1;

    // Input FIFO model: pushes from the stimulus, pops on the DUT strobe
    logic [WIDTH-1:0] q_mem [0:63];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    logic             flush = 1'b0;
    logic             in_hold = 1'b0;

    int cyc;
    int pop_cnt, wr_cnt, wr_cyc, v_cyc, both_cnt;
    logic [WIDTH-1:0] wr_data;
    int n_cmp = 0;
    int n_err = 0;

    channel_reduce_sum #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .valid           (valid),
        .out_in_data     (out_in_data),
        .out_read_valid  (out_read_valid),
        .out_rst         (out_rst),
        .out_write_valid (out_write_valid),
        .out_out_data    (out_out_data),
        .out_read_ready  (out_read_ready),
        .out_write_ready (out_write_ready),
        .in_in_data      (in_in_data),
        .in_read_valid   (in_read_valid),
        .in_rst          (in_rst),
        .in_write_valid  (in_write_valid),
        .in_out_data     (in_out_data),
        .in_read_ready   (in_read_ready),
        .in_write_ready  (in_write_ready)
    );

    always #5 clk = ~clk;

    assign in_read_ready = (wr_ptr != rd_ptr) && !in_hold;

    always @(posedge clk) begin
        if (flush) begin
            rd_ptr <= wr_ptr;
        end else if (in_read_valid) begin
            in_out_data <= q_mem[rd_ptr];
            rd_ptr      <= rd_ptr + 1;
        end
    end

    // Cycle N is the state reached after the Nth rising edge past reset release
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            pop_cnt = 0; wr_cnt = 0; wr_cyc = -1; v_cyc = -1; both_cnt = 0; wr_data = '0;
        end else begin
            if (in_read_valid) pop_cnt++;
            if (out_write_valid) begin
                wr_cnt++;
                wr_cyc  = cyc;
                wr_data = out_in_data;
            end
            if (in_read_valid && out_write_valid) both_cnt++;
            if (valid && v_cyc < 0) v_cyc = cyc;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic to_cycle(input int n);
        int guard = 0;
        while (cyc < n && guard < 300) begin
            step();
            guard++;
        end
    endtask

    task automatic wait_done(input string tag);
        int guard = 0;
        while (!valid && guard < 200) begin
            step();
            guard++;
        end
        check({tag, "_done_reached"}, 64'(valid), 64'd1);
    endtask

    task automatic do_reset(input string tag, input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                            input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w3);
        rst_n = 1'b0;
        flush = 1'b1;
        step();
        check({tag, "_reset_outs"},
              64'({valid, in_read_valid, out_write_valid, out_read_valid, in_write_valid, out_rst, in_rst}), 64'd0);
        check({tag, "_reset_acc"}, 64'(out_in_data), 64'd0);
        flush = 1'b0;
        q_mem[wr_ptr] = w0; wr_ptr++;
        q_mem[wr_ptr] = w1; wr_ptr++;
        q_mem[wr_ptr] = w2; wr_ptr++;
        q_mem[wr_ptr] = w3; wr_ptr++;
        step();
        rst_n = 1'b1;
    endtask

    task automatic check_run(input string tag, input logic [WIDTH-1:0] sum, input int wcyc);
        check({tag, "_sum"},       64'(wr_data), 64'(sum));
        check({tag, "_write_cyc"}, 64'(wr_cyc), 64'(wcyc));
        check({tag, "_valid_cyc"}, 64'(v_cyc), 64'(wcyc + 1));
        check({tag, "_pops"},      64'(pop_cnt), 64'(COUNT));
        check({tag, "_writes"},    64'(wr_cnt), 64'd1);
        check({tag, "_overlap"},   64'(both_cnt), 64'd0);
    endtask

    initial begin
        // Basic sum, both readies high: write at cycle 19, done at 20
        do_reset("t1", 32'd1, 32'd2, 32'd3, 32'd4);
        to_cycle(19);
        check("t1_valid_low_at_write", 64'(valid), 64'd0);
        wait_done("t1");
        step();
        check_run("t1", 32'd10, 19);
        check("t1_valid_sticky", 64'(valid), 64'd1);
        $display("t1 sum=%0d write_cyc=%0d valid_cyc=%0d", wr_data, wr_cyc, v_cyc);

        // Wraparound of the accumulator
        do_reset("t2", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0);
        wait_done("t2");
        check_run("t2", 32'h0000_0000, 19);
        $display("t2 sum=%0h write_cyc=%0d", wr_data, wr_cyc);

        // Input ready low for 5 WAIT_IN cycles before the second word
        do_reset("t3", 32'd10, 32'd20, 32'd30, 32'd40);
        to_cycle(4);
        in_hold = 1'b1;
        to_cycle(11);
        check("t3_pops_during_hold", 64'(pop_cnt), 64'd1);
        in_hold = 1'b0;
        wait_done("t3");
        check_run("t3", 32'd100, 24);
        $display("t3 sum=%0d write_cyc=%0d", wr_data, wr_cyc);

        // Output ready withheld until cycle 30
        out_write_ready = 1'b0;
        do_reset("t4", 32'd7, 32'd8, 32'd9, 32'd10);
        to_cycle(29);
        check("t4_no_write_yet", 64'(wr_cnt), 64'd0);
        out_write_ready = 1'b1;
        wait_done("t4");
        check_run("t4", 32'd34, 30);
        $display("t4 sum=%0d write_cyc=%0d", wr_data, wr_cyc);

        // Reset in the middle of a run discards the partial sum
        do_reset("t5a", 32'd100, 32'd200, 32'd300, 32'd400);
        to_cycle(8);
        check("t5_pops_before_abort", 64'(pop_cnt), 64'd2);
        rst_n = 1'b0;
        #1;
        check("t5_async_outs", 64'({valid, in_read_valid, out_write_valid}), 64'd0);
        check("t5_async_acc", 64'(out_in_data), 64'd0);
        do_reset("t5", 32'd5, 32'd5, 32'd5, 32'd5);
        wait_done("t5");
        check_run("t5", 32'd20, 19);
        $display("t5 sum=%0d write_cyc=%0d", wr_data, wr_cyc);

        // Ready toggling after completion causes no channel activity
        q_mem[wr_ptr] = 32'd1; wr_ptr++;
        q_mem[wr_ptr] = 32'd2; wr_ptr++;
        for (int i = 0; i < 20; i++) begin
            in_hold         = 1'($urandom_range(0, 1));
            out_write_ready = 1'($urandom_range(0, 1));
            step();
            check("t6_valid_held", 64'(valid), 64'd1);
        end
        check("t6_pops", 64'(pop_cnt), 64'(COUNT));
        check("t6_writes", 64'(wr_cnt), 64'd1);
        $display("t6 pops=%0d writes=%0d valid=%0b", pop_cnt, wr_cnt, valid);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
